regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the single register-file write port of the 18-bit processor between N_REQ write-back sources (ALU, load path, immediate-load path by default). It accepts requests through a req/gnt handshake, registers the winning address and data, and drives the 4-bit register select. That select feeds the register file's 4-to-16 write decoder, which produces the one-hot write enables. It sits between the execute/memory stages and the register file.

## Interface
- N_REQ, 3, number of write-back requesters (2..4)
- DATA_W, 18, register data width
- ADDR_W, 4, register select width (16 registers)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester write request; held until granted
- req_addr  in  N_REQ*ADDR_W  destination register per requester; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  write data per requester; requester i occupies bits [i*DATA_W +: DATA_W]
- stall  in  1  register-file port unavailable; blocks all grants
- gnt  out  N_REQ  combinational one-hot grant; a transfer occurs on an edge where req[i] & gnt[i]
- wr_en  out  1  registered write strobe to the register file
- wr_sel  out  ADDR_W  registered destination select, to the 4-to-16 write decoder
- wr_data  out  DATA_W  registered write data
- conflict  out  1  registered flag: more than one requester was active on the last transfer edge

## Operation
- State: round-robin pointer ptr (0..N_REQ-1), output registers wr_en/wr_sel/wr_data, and the conflict flag.
- Grant: when stall=0 and any req is high, gnt selects the first requester with req high, searching from ptr upward and wrapping modulo N_REQ. gnt=0 when stall=1 or req=0. gnt is always zero or one-hot.
- Transfer edge (some gnt[i]=1): wr_en<=1, wr_sel<=req_addr[i], wr_data<=req_data[i], ptr<=(i+1) mod N_REQ, conflict<=(popcount(req)>1).
- Idle edge (no grant): wr_en<=0, conflict<=0. wr_sel, wr_data and ptr hold.
- Requesters must hold req, addr and data stable until they see gnt high at an edge. On the edge after a grant, a requester may drop req or present a new request.
- Losing requesters are not acknowledged. Their req is retained and they win within N_REQ-1 further transfer edges (starvation-free).
- No address filtering: writes to any of the 16 registers, including register 0, pass through unchanged.
- Reset (rst_n=0, any time, including mid-transfer): wr_en=0, wr_sel=0, wr_data=0, conflict=0, ptr=0 immediately. gnt is 0 while reset is asserted. A transfer in flight at reset is dropped; the requester keeps req high and is re-arbitrated after release.

## Timing
- Request-to-write latency: 1 cycle. With req high and no stall at edge N, wr_en is high during cycle N+1 with the matching wr_sel/wr_data.
- Throughput: one write per cycle with no dead cycles. Back-to-back grants to different requesters are allowed on consecutive edges.
- gnt is combinational from req, stall and ptr. There is no combinational path from req_addr or req_data to any output.
- stall takes effect in the same cycle (gnt=0). The wr_en pulse already registered for the current cycle completes regardless of stall.
- The first edge after reset release arbitrates with ptr=0.

## Structure
- Shared package: constants REG_COUNT=16, REG_SEL_W=4, DATA_W=18, and default requester indices REQ_ALU=0, REQ_LOAD=1, REQ_IMM=2. The parameter defaults take their values from the package.
- One combinational sub-module, rr_pick: inputs req and ptr; outputs the one-hot gnt and the winner index. Instantiated once. The top module holds all registers.
- The one-hot write-enable expansion stays in the existing register-file decoder and is not duplicated here.

## Test plan
- Reset: assert rst_n=0 mid-transfer with req=3'b111 → wr_en=0, wr_sel=0, wr_data=0, conflict=0 and gnt=0 while reset is held. After release, the first grant goes to requester 0.
- Single request: req=3'b010, addr1=4'hA, data1=18'h2ABCD → gnt=3'b010 in the same cycle. In the next cycle wr_en=1, wr_sel=4'hA, wr_data=18'h2ABCD, conflict=0.
- Round-robin: req held at 3'b111 for 6 cycles → grant sequence 0,1,2,0,1,2; conflict=1 on every write; wr_en continuously high.
- Stall: req=3'b001 with stall=1 for 3 cycles → gnt=0 and wr_en=0 throughout, ptr unchanged. Releasing stall gives grant to requester 0 in that cycle and a write in the next cycle.
- Wrap/fairness: ptr=2 (last grant to requester 1) with req=3'b011 → grant to requester 0, not 1. Then req=3'b010 → requester 1 is granted on the following edge.
- Idle hold: after a write of 4'h5/18'h00011, req=0 for 4 cycles → wr_en=0 while wr_sel stays 4'h5 and wr_data stays 18'h00011.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write-back path of the 18-bit
// processor.
//
// Contents:
//   REG_COUNT, REG_SEL_W   register file geometry (16 registers, 4-bit select)
//   DATA_W                 register data width
//   REQ_ALU/REQ_LOAD/REQ_IMM  default write-back requester indices
//   N_REQ_DEFAULT          default number of write-back requesters
//   ptr_width()            width of a requester index for a given count
package regfile_write_arbiter_pkg;

    localparam int REG_COUNT = 16;
    localparam int REG_SEL_W = 4;
    localparam int DATA_W    = 18;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IMM  = 2;

    localparam int N_REQ_DEFAULT = REQ_IMM + 1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back bus between the requesters (execute/memory stages) and the
// arbiter, including the registered write port towards the register file.
//
// Handshake: a requester raises req[i] with req_addr/req_data for slot i and
// holds all three stable until it sees gnt[i]=1 at a rising edge; that edge
// is the transfer. gnt is combinational and is never high without req.
// stall=1 forces gnt to zero in the same cycle.
//
// Signals:
//   req, req_addr, req_data, stall   requester side -> arbiter
//   gnt                              arbiter -> requesters (one-hot or zero)
//   wr_en, wr_sel, wr_data           registered write port -> register file
//   conflict                         registered "more than one requester" flag
//
// Modports:
//   master  requester / environment side
//   slave   arbiter side
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEFAULT,
    parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W = REG_SEL_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    stall;
    logic [N_REQ-1:0]        gnt;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_sel;
    logic [DATA_W-1:0]       wr_data;
    logic                    conflict;

    modport master (
        output req, req_addr, req_data, stall,
        input  gnt, wr_en, wr_sel, wr_data, conflict
    );

    modport slave (
        input  req, req_addr, req_data, stall,
        output gnt, wr_en, wr_sel, wr_data, conflict
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin pick: starting at ptr_i and wrapping modulo
// N_REQ, selects the first requester with req_i high.
//
// Ports:
//   req_i   per-requester request vector
//   ptr_i   requester with highest priority this cycle
//   gnt_o   one-hot grant (zero when req_i is zero)
//   win_o   index of the granted requester (0 when nothing is granted)
//   any_o   some requester was picked
module regfile_write_arbiter_rr_pick
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int PTR_W = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] win_o,
    output logic             any_o
);

    always_comb begin
        int idx;
        gnt_o = '0;
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        // Visit requesters in priority order ptr, ptr+1, ... (wrapping);
        // the first one found wins and later ones are ignored.
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port. Grants one
// write-back requester per cycle, registers its destination select and data,
// and presents them to the register file's 4-to-16 write decoder one cycle
// after the grant.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        write-back bus (slave side): req/req_addr/req_data/stall in,
//              gnt/wr_en/wr_sel/wr_data/conflict out
//   dbg_ptr_o  current round-robin pointer (requester with top priority)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEFAULT,
    parameter int DATA_W = regfile_write_arbiter_pkg::DATA_W,
    parameter int ADDR_W = REG_SEL_W,
    localparam int PTR_W = ptr_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_arbiter_if.slave bus,
    output logic [PTR_W-1:0]     dbg_ptr_o
);

    logic [PTR_W-1:0]  ptr_q,      ptr_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_sel_q,   wr_sel_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              conflict_q, conflict_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]  pick_win;
    logic              pick_any;
    logic              xfer;

    regfile_write_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // A transfer needs a winner, a free port and a released reset; gating
    // with rst_n keeps gnt low while reset is held so no requester believes
    // it was accepted.
    assign xfer    = pick_any & ~bus.stall & rst_n;
    assign bus.gnt = xfer ? pick_gnt : '0;

    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_data_d  = wr_data_q;
        conflict_d = 1'b0;
        if (xfer) begin
            wr_en_d    = 1'b1;
            wr_sel_d   = bus.req_addr[pick_win*ADDR_W +: ADDR_W];
            wr_data_d  = bus.req_data[pick_win*DATA_W +: DATA_W];
            conflict_d = ($countones(bus.req) > 1);
            // Winner drops to lowest priority: the next one up gets first pick.
            if (pick_win == PTR_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_win + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= '0;
            wr_data_q  <= '0;
            conflict_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_sel   = wr_sel_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.conflict = conflict_q;
    assign dbg_ptr_o    = ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int N     = 3;
    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int PW    = 2;
    localparam int EXP_W = 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
    logic [PW-1:0] dbg_ptr;

    regfile_write_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_ptr_o (dbg_ptr)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [EXP_W-1:0] exp_q[$];   // {conflict, sel, data} per expected write
    int m_ptr = 0;                // model: requester with top priority
    int last_win = -1;
    logic [AW-1:0] hold_sel  = '0;
    logic [DW-1:0] hold_data = '0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Winner = requesting index with the smallest cyclic distance from the
    // priority pointer; -1 when nothing can be granted.
    function automatic int model_winner(input logic [N-1:0] r, input logic s, input int p);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        if (!s) begin
            for (int i = 0; i < N; i++) begin
                if (r[i] && (((i - p + N) % N) < bestd)) begin
                    bestd = (i - p + N) % N;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int ones(input logic [N-1:0] r);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(r[i]);
        return c;
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge; drives one cycle of inputs, checks
    // the combinational grant mid-cycle and records the expected write.
    task automatic drive_cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                               input logic [N*DW-1:0] d, input logic s);
        int w;
        logic [N-1:0] eg;
        logic c;
        bus.req      = r;
        bus.req_addr = a;
        bus.req_data = d;
        bus.stall    = s;
        w  = model_winner(r, s, m_ptr);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        @(negedge clk);
        check("gnt", 32'(bus.gnt), 32'(eg));
        @(posedge clk);
        if (w >= 0) begin
            c = (ones(r) > 1);
            exp_q.push_back({c, a[w*AW +: AW], d[w*DW +: DW]});
            m_ptr = (w + 1) % N;
        end
        last_win = w;
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle('0, N*AW'($urandom), {$urandom, $urandom}, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (mon_en && rst_n) begin
            if (bus.wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got wr_en=1 sel=%h data=%h expected no write at %0t",
                             bus.wr_sel, bus.wr_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_sel", 32'(bus.wr_sel), 32'(e[DW +: AW]));
                    check("wr_data", 32'(bus.wr_data), 32'(e[DW-1:0]));
                    check("conflict", 32'(bus.conflict), 32'(e[EXP_W-1]));
                    hold_sel  = e[DW +: AW];
                    hold_data = e[DW-1:0];
                end
            end else begin
                check("wr_en_idle", 32'(bus.wr_en), 32'd0);
                check("missing_write", 32'(exp_q.size()), 32'd0);
                check("idle_sel_hold", 32'(bus.wr_sel), 32'(hold_sel));
                check("idle_data_hold", 32'(bus.wr_data), 32'(hold_data));
                check("idle_conflict", 32'(bus.conflict), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0]    pend;
        logic [N*AW-1:0] pa;
        logic [N*DW-1:0] pd;
        int wait_cnt[N];

        rst_n        = 1'b0;
        bus.req      = 3'b111;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.stall    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_sel", 32'(bus.wr_sel), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_conflict", 32'(bus.conflict), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Round-robin: all three held for 6 edges -> 0,1,2,0,1,2.
        pa = N*AW'($urandom);
        pd = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(3'b111, pa, pd, 1'b0);
            check("rr_order", 32'(last_win), 32'(i % N));
        end

        // Single request from requester 1.
        drive_cycle(3'b010, 12'h0A0, {18'h0, 18'h2ABCD, 18'h0}, 1'b0);
        // Wrap: pointer now at 2, requesters 0 and 1 -> 0 wins, then 1.
        drive_cycle(3'b011, 12'h034, {18'h0, 18'h11111, 18'h22222}, 1'b0);
        check("wrap_first", 32'(last_win), 32'd0);
        drive_cycle(3'b010, 12'h034, {18'h0, 18'h11111, 18'h22222}, 1'b0);
        check("wrap_second", 32'(last_win), 32'd1);

        // Stall blocks everything and leaves the pointer alone.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(3'b001, 12'h007, {36'h0, 18'h3FFFF}, 1'b1);
            check("stall_ptr", 32'(dbg_ptr), 32'(m_ptr));
        end
        drive_cycle(3'b001, 12'h007, {36'h0, 18'h3FFFF}, 1'b0);
        check("stall_release", 32'(last_win), 32'd0);

        // Idle hold after a write of 5 / 0x00011.
        drive_cycle(3'b001, 12'h005, {36'h0, 18'h00011}, 1'b0);
        repeat (4) idle_cycle();
        @(negedge clk);
        check("hold_sel", 32'(bus.wr_sel), 32'h5);
        check("hold_data", 32'(bus.wr_data), 32'h00011);
        @(posedge clk);
        #1;

        // Reset in the middle of a transfer; requests stay up.
        drive_cycle(3'b111, 12'h9C3, {18'h1, 18'h2, 18'h3}, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        hold_sel  = '0;
        hold_data = '0;
        m_ptr     = 0;
        #1;
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_rst_wr_sel", 32'(bus.wr_sel), 32'd0);
        check("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("mid_rst_conflict", 32'(bus.conflict), 32'd0);
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_gnt_held", 32'(bus.gnt), 32'd0);
        rst_n = 1'b1;
        drive_cycle(3'b111, 12'h9C3, {18'h1, 18'h2, 18'h3}, 1'b0);
        check("post_rst_first", 32'(last_win), 32'd0);

        // Randomized traffic with the hold-until-granted protocol.
        pend = '0;
        pa   = '0;
        pd   = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pa[i*AW +: AW] = AW'($urandom);
                    pd[i*DW +: DW] = DW'($urandom);
                    if ($urandom_range(0, 1) == 1) pend[i] = 1'b1;
                end
            end
            drive_cycle(pend, pa, pd, ($urandom_range(0, 4) == 0));
            if (last_win >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && i != last_win) wait_cnt[i]++;
                end
                check("starvation_bound", 32'(wait_cnt[last_win] <= N - 1), 32'd1);
                wait_cnt[last_win] = 0;
                pend[last_win] = 1'b0;
            end
        end

        repeat (2) idle_cycle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
